reg_writeback: RTL

- Writeback stage directly upstream of the 16x32 register file.
- Merges two result sources into the file's single write port:
  - ALU results, valid/ready handshake.
  - In-order load responses from data memory, valid/ready handshake.
- Keeps a per-register busy scoreboard for outstanding loads and drives a decode stall so no instruction reads a stale register.

---
 rtl/reg_writeback.sv | 115 +++++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU results and in-order load responses onto one register-file write port.
// Keeps a load scoreboard and a decode stall. Define FWD_BYPASS_EN to add the write-port forwarding outputs.
module reg_writeback #(
   parameter int LOAD_DEPTH = 4,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              aluValid,
   output logic              aluReady,
   input  logic [3:0]        aluDestIndex,
   input  logic [DATA_W-1:0] aluResult,
   input  logic              memIssueValid,
   output logic              memIssueReady,
   input  logic [3:0]        memIssueIndex,
   input  logic              memRespValid,
   output logic              memRespReady,
   input  logic [DATA_W-1:0] memRespData,
   input  logic [3:0]        decRd0Index,
   input  logic [3:0]        decRd1Index,
   input  logic [3:0]        decWrIndex,
   output logic              decStall,
   output logic              regFileWrEn,
   output logic [3:0]        regFileWrIndex,
   output logic [DATA_W-1:0] regFileWrData,
   output logic [15:0]       busy,
   output logic              protoErr
`ifdef FWD_BYPASS_EN
   , output logic              fwdHit0
   , output logic              fwdHit1
   , output logic [DATA_W-1:0] fwdData0
   , output logic [DATA_W-1:0] fwdData1
`endif
);
   localparam int PW = $clog2(LOAD_DEPTH);
   localparam int CW = PW + 1;

   logic [3:0]        pend [LOAD_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              buf_full;
   logic [3:0]        buf_idx;
   logic [DATA_W-1:0] buf_data;
   logic              empty, issue, resp, sel_alu, cap, wr_en, err, inflight;
   logic [3:0]        head, wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic [15:0]       busy_nxt;

   assign empty         = count == '0;
   assign head          = pend[rd_ptr];
   assign aluReady      = !buf_full;
   assign memRespReady  = !buf_full;
   assign memIssueReady = count != CW'(LOAD_DEPTH);
   assign issue         = memIssueValid && memIssueReady;
   // a response with nothing pending is a protocol error and never wins the port
   assign resp          = !buf_full && memRespValid && !empty;
   assign sel_alu       = !buf_full && !resp && aluValid;
   assign cap           = resp && aluValid;
   assign wr_en         = buf_full || resp || sel_alu;
   assign wr_idx        = buf_full ? buf_idx : resp ? head : aluDestIndex;
   assign wr_data       = buf_full ? buf_data : resp ? memRespData : aluResult;
   assign busy_nxt      = (busy & ~(resp ? 16'(1) << head : 16'd0)) | (issue ? 16'(1) << memIssueIndex : 16'd0);
   assign err           = (memRespValid && empty) || (memIssueValid && busy[memIssueIndex]) ||
                          (aluValid && busy[aluDestIndex]);

`ifdef FWD_BYPASS_EN
   assign fwdHit0  = regFileWrEn && regFileWrIndex == decRd0Index;
   assign fwdHit1  = regFileWrEn && regFileWrIndex == decRd1Index;
   assign fwdData0 = regFileWrData;
   assign fwdData1 = regFileWrData;
   assign inflight = 1'b0;
`else
   // the register file has not committed the write being presented this cycle
   assign inflight = regFileWrEn && (regFileWrIndex == decRd0Index || regFileWrIndex == decRd1Index);
`endif

   assign decStall = busy[decRd0Index] || busy[decRd1Index] || busy[decWrIndex] ||
                     (memIssueValid && !memIssueReady) || inflight;

   always_ff @(posedge clk) begin
      if (issue) pend[wr_ptr] <= memIssueIndex;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regFileWrEn    <= 1'b0;
         regFileWrIndex <= '0;
         regFileWrData  <= '0;
         buf_full       <= 1'b0;
         buf_idx        <= '0;
         buf_data       <= '0;
         busy           <= '0;
         protoErr       <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
      end else begin
         regFileWrEn <= wr_en;
         if (wr_en) begin
            regFileWrIndex <= wr_idx;
            regFileWrData  <= wr_data;
         end
         buf_full <= cap;
         if (cap) begin
            buf_idx  <= aluDestIndex;
            buf_data <= aluResult;
         end
         busy     <= busy_nxt;
         protoErr <= protoErr || err;
         if (issue) wr_ptr <= wr_ptr + PW'(1);
         if (resp) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(issue) - CW'(resp);
      end
   end
endmodule
